mp_subtractor: RTL and testbench

MP_SUBTRACTOR -- requirements
Module: mp_subtractor

---
 rtl/mp_pkg.sv | 21 ++
 rtl/mp_limb_sub.sv | 19 +
 rtl/mp_subtractor.sv | 126 ++++++++++++
 tb/tb_mp_subtractor.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared types and default sizing for the multi-precision subtractor.
// NEG state exists only when MPSUB_ABS_EN is defined.
package mp_pkg;

    localparam int WIDTH_DEF = 128;
    localparam int LIMB_DEF  = 64;

    function automatic int nlimb(input int width, input int limb);
        return width / limb;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
`ifdef MPSUB_ABS_EN
        NEG  = 2'd2,
`endif
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mp_limb_sub.sv
// One combinational LIMB-bit subtract stage: d = a - b - bin, with borrow-out.
module mp_limb_sub #(
    parameter int LIMB = 64
) (
    input  logic [LIMB-1:0] a,
    input  logic [LIMB-1:0] b,
    input  logic            bin,
    output logic [LIMB-1:0] d,
    output logic            bout
);

    logic [LIMB:0] diff;

    // A negative result sets the extra top bit, which is exactly the borrow-out.
    assign diff = {1'b0, a} - {1'b0, b} - {{LIMB{1'b0}}, bin};
    assign d    = diff[LIMB-1:0];
    assign bout = diff[LIMB];

endmodule

// File: rtl/mp_subtractor.sv
// Limb-serial WIDTH-bit subtractor: C = A - B over NLIMB cycles, plus final borrow.
// Define MPSUB_ABS_EN to negate a borrowing result in place, giving |A - B|.
module mp_subtractor
    import mp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LIMB  = LIMB_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             borrow,
    output logic             done,
    output logic             busy
);

    localparam int NLIMB = nlimb(WIDTH, LIMB);
    localparam int CNT_W = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, c_next;
    logic [CNT_W-1:0] cnt;
    logic             chain;
    logic [LIMB-1:0]  op_a, op_b, d;
    logic             bout, last;

    assign last = (cnt == CNT_W'(NLIMB - 1));

    always_comb begin
        op_a = a_sh[LIMB-1:0];
        op_b = b_sh[LIMB-1:0];
`ifdef MPSUB_ABS_EN
        if (state == NEG) begin
            op_a = '0;
            op_b = C[LIMB-1:0];
        end
`endif
    end

    mp_limb_sub #(.LIMB(LIMB)) u_limb (
        .a    (op_a),
        .b    (op_b),
        .bin  (chain),
        .d    (d),
        .bout (bout)
    );

    // Each new limb enters at the MSB end; after NLIMB shifts C is fully aligned.
    assign c_next = (C >> LIMB) | (WIDTH'(d) << (WIDTH - LIMB));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SUB;
            SUB: if (last) begin
`ifdef MPSUB_ABS_EN
                state_nxt = bout ? NEG : DONE;
`else
                state_nxt = DONE;
`endif
            end
`ifdef MPSUB_ABS_EN
            NEG: if (last) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done = (state == DONE);
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            C      <= '0;
            cnt    <= '0;
            chain  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh   <= A;
                    b_sh   <= B;
                    cnt    <= '0;
                    chain  <= 1'b0;
                    borrow <= 1'b0;
                end
                SUB: begin
                    C    <= c_next;
                    a_sh <= a_sh >> LIMB;
                    b_sh <= b_sh >> LIMB;
                    // The chain restarts at 0 so a following NEG pass begins clean.
                    if (last) begin
                        cnt    <= '0;
                        chain  <= 1'b0;
                        borrow <= bout;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        chain <= bout;
                    end
                end
`ifdef MPSUB_ABS_EN
                NEG: begin
                    C     <= c_next;
                    chain <= last ? 1'b0 : bout;
                    cnt   <= last ? '0 : cnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_subtractor.sv
// Directed self-checking bench for mp_subtractor at default WIDTH=128, LIMB=64.
module tb_mp_subtractor;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] A, B, C;
    logic         borrow, done, busy;

    int checks = 0;
    int errors = 0;

    mp_subtractor #(.WIDTH(128), .LIMB(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .C      (C),
        .borrow (borrow),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start is raised in cycle 0; cycle k is observed #1 after the k-th following edge.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ec, input logic eb, input int elat);
        int lat;
        lat   = 0;
        A     = a;
        B     = b;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) begin
                start = 1'b0;
                A     = ~a;
                B     = ~b;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, W'(lat), W'(elat));
        check({tag, " C"}, C, ec);
        check({tag, " borrow"}, W'(borrow), W'(eb));
        tick();
        check({tag, " hold C"}, C, ec);
        check({tag, " done one cycle"}, W'(done), '0);
    endtask

    initial begin
        logic [15:0] mask;
        int          seen;

        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #12;
        check("reset C", C, '0);
        check("reset borrow", W'(borrow), '0);
        check("reset done", W'(done), '0);
        check("reset busy", W'(busy), '0);
        tick();
        reset = 1'b0;

        run_op("simple", 128'd5, 128'd3, 128'd2, 1'b0, 3);
        run_op("limb borrow", 128'h1_0000_0000_0000_0000, 128'd1,
               128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 1'b0, 3);
        run_op("mixed", 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
               128'h0000_0000_0000_0001_FEDC_BA98_7654_3211,
               128'h0123_4567_89AB_CDED_FFFF_FFFF_FFFF_FFFF, 1'b0, 3);
        run_op("equal", 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
               128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, '0, 1'b0, 3);
        run_op("max minus zero", '1, '0, '1, 1'b0, 3);
`ifdef MPSUB_ABS_EN
        run_op("underflow", 128'd0, 128'd1, 128'd1, 1'b1, 5);
        run_op("underflow high", 128'd1, 128'h1_0000_0000_0000_0001,
               128'h1_0000_0000_0000_0000, 1'b1, 5);
`else
        run_op("underflow", 128'd0, 128'd1, '1, 1'b1, 3);
        run_op("underflow high", 128'd1, 128'h1_0000_0000_0000_0001,
               128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, 1'b1, 3);
`endif

        // Held start: accepted in cycles 0, 4, 8 -> done in 3, 7, 11.
        A     = 128'h1234;
        B     = 128'h1234;
        start = 1'b1;
        mask  = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 10) start = 1'b0;
            if (k == 2) check("held busy in SUB", W'(busy), W'(1));
            if (k == 4) check("held busy in IDLE", W'(busy), '0);
            if (done) begin
                mask[k] = 1'b1;
                check("held C", C, '0);
                check("held borrow", W'(borrow), '0);
            end
        end
        check("held done cycles", W'(mask), W'(16'h0888));

        // Reset in cycle 2 of an operation whose partial C is already nonzero.
        A     = 128'd5;
        B     = 128'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("midreset C", C, '0);
        check("midreset busy", W'(busy), '0);
        check("midreset done", W'(done), '0);
        check("midreset borrow", W'(borrow), '0);
        tick();
        reset = 1'b0;
        seen  = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) seen++;
        end
        check("midreset no done", W'(seen), '0);
        run_op("after reset", 128'd9, 128'd4, 128'd5, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
